fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the rv32i pipeline: owns the program counter, issues reads on the instruction-memory interface, and hands each returned instruction with its PC to the IF/ID stage register. Holds a fetched instruction while the downstream pipeline stalls. Handles control-flow redirects, including a redirect that arrives while a memory read is still outstanding.

## Interface
- RESET_PC, 32'h0000_0060, PC loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_read  out  1  instruction read request; held high until imem_resp.
- imem_address  out  32  word-aligned read address; stable while imem_read is high.
- imem_rdata  in  32  read data, valid when imem_resp is high.
- imem_resp  in  1  one-cycle read-complete pulse.
- stall_i  in  1  downstream cannot accept an instruction this cycle.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- valid_o  out  1  pc_o and ir_o carry an instruction.
- pc_o  out  32  PC of the offered instruction.
- ir_o  out  32  offered instruction word.
- load_o  out  1  IF/ID load strobe: valid_o && !stall_i && !redirect_i.

## Operation
- State register fetch_state_t has three states:
  - FETCH: request in flight.
  - HOLD: instruction buffered under stall.
  - DRAIN: discarding a stale response.
- Registers: pc, req_addr (address of the outstanding request), ir_buf.
- Transfer rule: an instruction transfers when load_o = 1. pc then advances by 4, wrapping 32'hFFFF_FFFC to 32'h0.

FETCH
- imem_read = 1, imem_address = pc.
- On imem_resp with !stall_i: valid_o = 1, ir_o = imem_rdata, pc_o = pc. Transfer; stay in FETCH. The next request (pc+4) is issued the following cycle.
- On imem_resp with stall_i: capture imem_rdata into ir_buf and go to HOLD. pc is unchanged.

HOLD
- imem_read = 0, valid_o = 1, ir_o = ir_buf, pc_o = pc.
- On !stall_i: transfer, then go to FETCH.

DRAIN
- imem_read = 1, imem_address = req_addr, valid_o = 0.
- On imem_resp: discard the data and go to FETCH, which fetches the current pc.

Redirect (priority over stall and response)
- pc <= {redirect_pc_i[31:2], 2'b00}. valid_o may be high, but load_o = 0 and the offered instruction is dropped.
- FETCH without imem_resp: go to DRAIN. req_addr keeps the old address.
- FETCH with imem_resp in the same cycle: the response is discarded; stay in FETCH.
- HOLD: ir_buf is discarded; go to FETCH.
- DRAIN: pc updates to the newest target; stay in DRAIN.

Reset
- While rst is high: imem_read = 0, valid_o = 0, load_o = 0, pc = RESET_PC, pc_o = RESET_PC, ir_o = 0, state = FETCH.
- Reset mid-request abandons the request. Instruction memory is reset by the same rst.

## Timing
- Latency: request to offer is the memory latency. imem_resp cycle to IF/ID load is 0 cycles (combinational pass-through).
- Back-to-back issue: one instruction per (memory latency + 1) cycles.
- ir_o and pc_o are combinational from state, ir_buf, pc and imem_rdata. imem_read and imem_address are registered-state driven only, with no combinational path from imem_resp.
- Any change of imem_address while imem_read is high is a protocol violation.
- Redirect takes effect on the next clock edge. The first request to the target is issued the cycle after the redirect, or the cycle after the stale response in DRAIN.

## Structure
- fetch_state_t enum (FETCH, HOLD, DRAIN) goes in rv32i_types.
- RESET_PC stays a module parameter.
- Single module with no sub-module. The pc/req_addr/ir_buf registers are simple enough to stay inline.

## Test plan
- Reset release, memory latency 2: imem_read rises the cycle after rst drops, with imem_address = 32'h60. The response 32'h00000013 produces load_o = 1, pc_o = 32'h60. The next request goes to 32'h64.
- stall_i high on the response cycle for 3 cycles: valid_o = 1 and ir_o held for 3 cycles with load_o = 0 and imem_read = 0. load_o = 1 in the cycle stall_i drops.
- redirect_i to 32'h200 two cycles into an outstanding read of 32'h64: imem_address stays 32'h64 until imem_resp. No load_o on that response. The next request goes to 32'h200.
- redirect_i coincident with imem_resp: load_o = 0, and the next request goes to the target.
- redirect_i while in HOLD with stall_i high: the buffered instruction is dropped, and fetch of the target starts the next cycle.
- pc at 32'hFFFF_FFFC, transfer: the next request goes to 32'h0. redirect_pc_i = 32'h203 yields a request to 32'h200.

Source files
------------

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared types and helpers for the rv32i pipeline.
//   fetch_state_t : fetch stage control state
//   PC_STEP       : PC increment per sequential instruction
//   word_align    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request in flight
    HOLD  = 2'd1,  // instruction buffered under stall
    DRAIN = 2'd2   // discarding a stale response
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// offers each returned word with its PC to the IF/ID register. Buffers the
// word while downstream stalls and handles redirects, including one that
// lands while a read is still outstanding.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem_read       read request, held until imem_resp
//   imem_address    word-aligned read address, stable while imem_read is high
//   imem_rdata      read data, valid with imem_resp
//   imem_resp       one-cycle read-complete pulse
//   stall_i         downstream cannot accept this cycle
//   redirect_i      flush and restart at redirect_pc_i
//   redirect_pc_i   redirect target (bits [1:0] ignored)
//   valid_o         pc_o / ir_o carry an instruction
//   pc_o, ir_o      offered PC and instruction word
//   load_o          IF/ID load strobe
// ---------------------------------------------------------------------------
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic        load_o
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  req_addr_r, req_addr_s;  // address of the outstanding request
  logic [31:0]  ir_buf_r, ir_buf_s;

  logic         read_s;
  logic [31:0]  addr_s;
  logic         valid_s;
  logic [31:0]  ir_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_inc_s;

  // Redirect target and sequential successor; the 32-bit add wraps
  // 32'hFFFF_FFFC to 32'h0 on its own.
  assign target_s = word_align(redirect_pc_i);
  assign pc_inc_s = pc_r + PC_STEP;

  // Next-state, next-register values and raw (pre-reset-gating) outputs.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    req_addr_s = req_addr_r;
    ir_buf_s   = ir_buf_r;
    read_s     = 1'b0;
    addr_s     = pc_r;
    valid_s    = 1'b0;
    ir_s       = 32'h0000_0000;

    case (state_r)
      FETCH: begin
        read_s  = 1'b1;
        addr_s  = pc_r;
        valid_s = imem_resp;
        ir_s    = imem_rdata;
        if (redirect_i) begin
          pc_s = target_s;
          if (imem_resp) begin
            // Read already completed: drop the word, next request is the target.
            state_s = FETCH;
          end else begin
            // Read still in flight: remember its address so the request
            // stays stable until the stale response arrives.
            state_s    = DRAIN;
            req_addr_s = pc_r;
          end
        end else if (imem_resp) begin
          if (!stall_i) begin
            pc_s    = pc_inc_s;
            state_s = FETCH;
          end else begin
            ir_buf_s = imem_rdata;
            state_s  = HOLD;
          end
        end else begin
          state_s = FETCH;
        end
      end

      HOLD: begin
        read_s  = 1'b0;
        valid_s = 1'b1;
        ir_s    = ir_buf_r;
        if (redirect_i) begin
          pc_s    = target_s;
          state_s = FETCH;
        end else if (!stall_i) begin
          pc_s    = pc_inc_s;
          state_s = FETCH;
        end else begin
          state_s = HOLD;
        end
      end

      DRAIN: begin
        read_s  = 1'b1;
        addr_s  = req_addr_r;
        valid_s = 1'b0;
        if (redirect_i) begin
          // Only the target moves; the stale read must still be drained.
          pc_s    = target_s;
          state_s = DRAIN;
        end else if (imem_resp) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end

      default: begin
        // Unreachable encoding: restart fetch at the current PC.
        state_s = FETCH;
      end
    endcase
  end

  // Drive outputs, forcing reset values while rst is high.
  always_comb begin
    if (rst) begin
      imem_read    = 1'b0;
      imem_address = RESET_PC;
      valid_o      = 1'b0;
      pc_o         = RESET_PC;
      ir_o         = 32'h0000_0000;
      load_o       = 1'b0;
    end else begin
      imem_read    = read_s;
      imem_address = addr_s;
      valid_o      = valid_s;
      pc_o         = pc_r;
      ir_o         = ir_s;
      load_o       = valid_s && !stall_i && !redirect_i;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      ir_buf_r   <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      req_addr_r <= req_addr_s;
      ir_buf_r   <= ir_buf_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit against a latency-configurable instruction memory and a
// transaction-level reference model: the model tracks the next PC to deliver,
// whether an instruction is being held, and whether the outstanding memory
// transaction was made stale by a redirect.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic        load_o;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .ir_o         (ir_o),
    .load_o       (load_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_held_ir;

  // Memory model state
  bit          mem_busy;
  bit          mem_stale;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  bit          lat_rand;
  logic [31:0] last_req;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // True when the memory will pulse imem_resp in the coming cycle.
  function automatic bit resp_next();
    return !rst && mem_busy && (mem_cnt == 1);
  endfunction

  // One clock cycle: drive inputs at negedge, check outputs, update models.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit          resp;
    bit          exp_valid;
    logic [31:0] exp_ir;
    if (rst) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end
    resp = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      resp = (mem_cnt == 0);
    end
    imem_resp     = resp;
    imem_rdata    = resp ? mem_word(mem_addr) : 32'($urandom);
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rd ? rpc : 32'($urandom);
    #1;
    if (rst) begin
      check_val("rst_imem_read", 32'(imem_read), 32'd0);
      check_val("rst_valid", 32'(valid_o), 32'd0);
      check_val("rst_load", 32'(load_o), 32'd0);
      check_val("rst_pc_o", pc_o, RESET_PC);
      check_val("rst_ir_o", ir_o, 32'd0);
      m_pc   = RESET_PC;
      m_held = 1'b0;
    end else begin
      exp_valid = m_held || (resp && !mem_stale);
      exp_ir    = m_held ? m_held_ir : imem_rdata;
      check_val("valid_o", 32'(valid_o), 32'(exp_valid));
      check_val("load_o", 32'(load_o), 32'(exp_valid && !st && !rd));
      if (exp_valid) begin
        check_val("pc_o", pc_o, m_pc);
        check_val("ir_o", ir_o, exp_ir);
      end
      check_val("imem_read", 32'(imem_read), 32'(!m_held));
      if (mem_busy) begin
        check_val("addr_stable", imem_address, mem_addr);
      end else if (imem_read) begin
        check_val("req_addr", imem_address, m_pc);
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_cnt   = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
        mem_addr  = imem_address;
        last_req  = imem_address;
      end
      // Model update from the rules of this cycle
      if (rd) begin
        m_pc   = rpc & 32'hFFFF_FFFC;
        m_held = 1'b0;
        if (mem_busy && !resp) mem_stale = 1'b1;
      end else if (exp_valid && !st) begin
        m_pc   = m_pc + 32'd4;
        m_held = 1'b0;
      end else if (exp_valid && !m_held) begin
        m_held    = 1'b1;
        m_held_ir = imem_rdata;
      end
      if (resp) begin
        mem_busy  = 1'b0;
        mem_stale = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle until the response cycle, then apply the given stimulus on it.
  task automatic run_to_resp(input bit st, input bit rd, input logic [31:0] rpc);
    int guard = 0;
    while (!resp_next() && guard < 20) begin
      step(1'b0, 1'b0, 32'd0);
      guard++;
    end
    check_val("resp_wait", 32'(resp_next()), 32'd1);
    step(st, rd, rpc);
  endtask

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = 32'd0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    mem_busy = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
    lat_cfg = 2; lat_rand = 1'b0; last_req = 32'hDEAD_BEEF;
    m_pc = RESET_PC; m_held = 1'b0; m_held_ir = 32'd0;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    // Reset release: first request at RESET_PC, then 0x64
    step(1'b0, 1'b0, 32'd0);
    check_val("first_req", last_req, 32'h0000_0060);
    run_to_resp(1'b0, 1'b0, 32'd0);
    lat_cfg = 3;
    step(1'b0, 1'b0, 32'd0);
    check_val("second_req", last_req, 32'h0000_0064);

    // Redirect two cycles into the outstanding 0x64 read
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 32'd0);            // stale response, discarded
    lat_cfg = 2;
    step(1'b0, 1'b0, 32'd0);
    check_val("drain_target_req", last_req, 32'h0000_0200);

    // Redirect coincident with the response
    run_to_resp(1'b0, 1'b1, 32'h0000_0300);
    step(1'b0, 1'b0, 32'd0);
    check_val("coincident_req", last_req, 32'h0000_0300);

    // Stall for three cycles on the response, released on the fourth
    run_to_resp(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_val("after_hold_req", last_req, 32'h0000_0304);

    // Redirect while holding under stall
    run_to_resp(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0400);
    step(1'b0, 1'b0, 32'd0);
    check_val("hold_redirect_req", last_req, 32'h0000_0400);

    // PC wrap and target alignment
    run_to_resp(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    check_val("top_req", last_req, 32'hFFFF_FFFC);
    run_to_resp(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_val("wrap_req", last_req, 32'h0000_0000);
    run_to_resp(1'b0, 1'b1, 32'h0000_0203);
    step(1'b0, 1'b0, 32'd0);
    check_val("aligned_req", last_req, 32'h0000_0200);

    // Randomized traffic with variable memory latency
    lat_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] rpc;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      st = ($urandom_range(0, 99) < 35);
      rd = ($urandom_range(0, 99) < 8);
      // A redirect on the very cycle a stale read completes is left out of
      // the random mix.
      if (mem_stale && resp_next()) rd = 1'b0;
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = 32'hFFFF_FFF9;
        2:       rpc = 32'h0000_0203;
        default: rpc = 32'($urandom);
      endcase
      step(st, rd, rpc);
      if (rst) begin
        step(1'b0, 1'b0, 32'd0);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
